ars_ladder_ctrl: RTL and testbench

Montgomery-ladder scheduler for GF(2^233) scalar multiplication in the ECC signing path. It scans a scalar k from MSB to LSB and, for each ladder bit, launches one projective point-add and one point-double unit in parallel. Both units use the level-enable / rdy handshake. The controller owns the ladder registers (X1,Z1),(X2,Z2) and routes them to and from the units. It hands the final projective pair to the downstream affine-conversion stage.

---
 rtl/ars_ecc_pkg.sv | 28 ++
 rtl/ars_ladder_ctrl_if.sv | 52 +++++
 rtl/ars_unit_hs.sv | 52 +++++
 rtl/ars_ladder_ctrl.sv | 232 +++++++++++++++++++++++
 tb/tb_ars_ladder_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ars_ecc_pkg.sv
// ars_ecc_pkg
// Shared constants and types for the GF(2^233) Montgomery-ladder scheduler.
//   M   : field element width
//   KW  : scalar width
//   IW  : width of the ladder bit index
//   ONE : projective Z coordinate of an affine point
//   ladder_state_t : controller states
package ars_ecc_pkg;

    localparam int M  = 233;
    localparam int KW = 233;
    localparam int IW = $clog2(KW);

    localparam logic [M-1:0] ONE = {{(M-1){1'b0}}, 1'b1};

    typedef enum logic [3:0] {
        IDLE,
        SCAN,
        INIT,
        DBL0,
        GAP,
        STEP,
        WB,
        DONE,
        ERR
    } ladder_state_t;

endpackage

// File: rtl/ars_ladder_ctrl_if.sv
// ars_ladder_ctrl_if
// Bundles the host run/result signals and both point-unit handshakes.
//   slave  : the ladder controller's view
//   master : the environment's view (host plus point-add/point-double units)
// Host side : en, k, x0 -> rdy, err, X1, Z1, X2, Z2
// Add unit  : pa_en, pa_x0 (operands X1..Z2) -> pa_rdy, pa_X3, pa_Z3
// Dbl unit  : pd_en, pd_X, pd_Z -> pd_rdy, pd_X3, pd_Z3
interface ars_ladder_ctrl_if;
    import ars_ecc_pkg::*;

    logic          en;
    logic [KW-1:0] k;
    logic [M-1:0]  x0;
    logic          rdy;
    logic          err;
    logic [M-1:0]  X1;
    logic [M-1:0]  Z1;
    logic [M-1:0]  X2;
    logic [M-1:0]  Z2;

    logic          pa_en;
    logic          pa_rdy;
    logic [M-1:0]  pa_X3;
    logic [M-1:0]  pa_Z3;
    logic [M-1:0]  pa_x0;

    logic          pd_en;
    logic          pd_rdy;
    logic [M-1:0]  pd_X;
    logic [M-1:0]  pd_Z;
    logic [M-1:0]  pd_X3;
    logic [M-1:0]  pd_Z3;

    modport slave (
        input  en, k, x0,
        input  pa_rdy, pa_X3, pa_Z3,
        input  pd_rdy, pd_X3, pd_Z3,
        output rdy, err, X1, Z1, X2, Z2,
        output pa_en, pa_x0,
        output pd_en, pd_X, pd_Z
    );

    modport master (
        output en, k, x0,
        output pa_rdy, pa_X3, pa_Z3,
        output pd_rdy, pd_X3, pd_Z3,
        input  rdy, err, X1, Z1, X2, Z2,
        input  pa_en, pa_x0,
        input  pd_en, pd_X, pd_Z
    );

endinterface

// File: rtl/ars_unit_hs.sv
// ars_unit_hs
// Level-enable / rdy handshake for one external point unit.
// A start pulse raises unit_en and clears done. The first cycle rdy is
// sampled high while unit_en is set, the result is copied into the shadow
// registers, done is set and unit_en drops. rdy is ignored while unit_en is low.
//   clk, rst      : clock, asynchronous active-high reset
//   clr           : synchronous return to idle
//   start         : launch the unit
//   rdy           : unit done
//   res_x, res_z  : unit result
//   unit_en       : unit enable
//   done          : result captured
//   sh_x, sh_z    : captured result
module ars_unit_hs
    import ars_ecc_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         start,
    input  logic         rdy,
    input  logic [M-1:0] res_x,
    input  logic [M-1:0] res_z,
    output logic         unit_en,
    output logic         done,
    output logic [M-1:0] sh_x,
    output logic [M-1:0] sh_z
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            unit_en <= 1'b0;
            done    <= 1'b0;
            sh_x    <= '0;
            sh_z    <= '0;
        end else if (clr) begin
            unit_en <= 1'b0;
            done    <= 1'b0;
            sh_x    <= '0;
            sh_z    <= '0;
        end else if (start) begin
            unit_en <= 1'b1;
            done    <= 1'b0;
        end else if (unit_en && rdy) begin
            unit_en <= 1'b0;
            done    <= 1'b1;
            sh_x    <= res_x;
            sh_z    <= res_z;
        end
    end

endmodule

// File: rtl/ars_ladder_ctrl.sv
// ars_ladder_ctrl
// Montgomery-ladder scheduler for GF(2^233) scalar multiplication. Scans k
// from MSB to LSB; for each bit below the leading one it runs one point-add
// and one point-double in parallel and writes the pair back into
// (X1,Z1),(X2,Z2). On completion P1 = kP sits in (X1,Z1), P2 = (k+1)P in (X2,Z2).
//   clk : clock, rising edge
//   rst : asynchronous active-high reset
//   bus : ars_ladder_ctrl_if.slave (host run/result, add and double handshakes)
// Build option ARS_LADDER_CT_EN: constant-time mode. Leading zero bits each
// run a dummy STEP whose results are dropped, so latency depends only on KW.
module ars_ladder_ctrl
    import ars_ecc_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    ars_ladder_ctrl_if.slave bus
);

    ladder_state_t state;
    ladder_state_t state_nx;

    logic [KW-1:0] k_q;
    logic [M-1:0]  x0_q;
    logic [M-1:0]  x1_q;
    logic [M-1:0]  z1_q;
    logic [M-1:0]  x2_q;
    logic [M-1:0]  z2_q;
    logic [IW-1:0] idx;
    logic          live;
    logic          kbit;

    logic          pa_done;
    logic          pd_done;
    logic [M-1:0]  pa_sx;
    logic [M-1:0]  pa_sz;
    logic [M-1:0]  pd_sx;
    logic [M-1:0]  pd_sz;

    logic          clr;
    logic          latch;
    logic          load_init;
    logic          wr_dbl0;
    logic          wr_back;
    logic          dec_i;
    logic          start_pa;
    logic          start_pd;

    assign kbit = k_q[idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Unit starts are issued on the transition into DBL0/STEP so the
    // registered enables rise together with the new state.
    always_comb begin
        state_nx  = state;
        clr       = 1'b0;
        latch     = 1'b0;
        load_init = 1'b0;
        wr_dbl0   = 1'b0;
        wr_back   = 1'b0;
        dec_i     = 1'b0;
        start_pa  = 1'b0;
        start_pd  = 1'b0;
        if (!bus.en) begin
            state_nx = IDLE;
            clr      = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    latch    = 1'b1;
                    state_nx = SCAN;
                end
                SCAN: begin
                    if (k_q == '0) begin
                        state_nx = ERR;
                    end else if (kbit) begin
                        state_nx = INIT;
                    end else begin
`ifdef ARS_LADDER_CT_EN
                        state_nx = GAP;
`else
                        dec_i    = 1'b1;
`endif
                    end
                end
                INIT: begin
                    load_init = 1'b1;
                    start_pd  = 1'b1;
                    state_nx  = DBL0;
                end
                DBL0: begin
                    if (pd_done) begin
                        wr_dbl0 = 1'b1;
                        if (idx == '0) begin
                            state_nx = DONE;
                        end else begin
                            dec_i    = 1'b1;
                            state_nx = GAP;
                        end
                    end
                end
                GAP: begin
                    start_pa = 1'b1;
                    start_pd = 1'b1;
                    state_nx = STEP;
                end
                STEP: begin
                    if (pa_done && pd_done) begin
                        state_nx = WB;
                    end
                end
                WB: begin
                    wr_back = 1'b1;
                    if (idx == '0) begin
                        state_nx = DONE;
                    end else begin
                        dec_i = 1'b1;
                        // A dummy step that precedes the leading one hands over to INIT.
                        if (!live && k_q[idx - 1'b1]) begin
                            state_nx = INIT;
                        end else begin
                            state_nx = GAP;
                        end
                    end
                end
                DONE: state_nx = DONE;
                ERR:  state_nx = ERR;
                default: state_nx = IDLE;
            endcase
        end
    end

    // live marks that the leading one has been reached; write-backs before
    // that point belong to dummy steps and are dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k_q  <= '0;
            x0_q <= '0;
            x1_q <= '0;
            z1_q <= '0;
            x2_q <= '0;
            z2_q <= '0;
            idx  <= IW'(KW - 1);
            live <= 1'b0;
        end else if (clr) begin
            k_q  <= '0;
            x0_q <= '0;
            x1_q <= '0;
            z1_q <= '0;
            x2_q <= '0;
            z2_q <= '0;
            idx  <= IW'(KW - 1);
            live <= 1'b0;
        end else begin
            if (latch) begin
                k_q  <= bus.k;
                x0_q <= bus.x0;
            end
            if (load_init) begin
                x1_q <= x0_q;
                z1_q <= ONE;
                live <= 1'b1;
            end
            if (wr_dbl0) begin
                x2_q <= pd_sx;
                z2_q <= pd_sz;
            end
            if (wr_back && live) begin
                if (kbit) begin
                    x1_q <= pa_sx;
                    z1_q <= pa_sz;
                    x2_q <= pd_sx;
                    z2_q <= pd_sz;
                end else begin
                    x2_q <= pa_sx;
                    z2_q <= pa_sz;
                    x1_q <= pd_sx;
                    z1_q <= pd_sz;
                end
            end
            if (dec_i) begin
                idx <= idx - 1'b1;
            end
        end
    end

    ars_unit_hs u_pa (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .start   (start_pa),
        .rdy     (bus.pa_rdy),
        .res_x   (bus.pa_X3),
        .res_z   (bus.pa_Z3),
        .unit_en (bus.pa_en),
        .done    (pa_done),
        .sh_x    (pa_sx),
        .sh_z    (pa_sz)
    );

    ars_unit_hs u_pd (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .start   (start_pd),
        .rdy     (bus.pd_rdy),
        .res_x   (bus.pd_X3),
        .res_z   (bus.pd_Z3),
        .unit_en (bus.pd_en),
        .done    (pd_done),
        .sh_x    (pd_sx),
        .sh_z    (pd_sz)
    );

    // In STEP a set bit doubles P2, a clear bit doubles P1; DBL0 doubles P1.
    assign bus.pd_X  = (state == STEP && kbit) ? x2_q : x1_q;
    assign bus.pd_Z  = (state == STEP && kbit) ? z2_q : z1_q;
    assign bus.pa_x0 = x0_q;
    assign bus.X1    = x1_q;
    assign bus.Z1    = z1_q;
    assign bus.X2    = x2_q;
    assign bus.Z2    = z2_q;
    assign bus.rdy   = (state == DONE);
    assign bus.err   = (state == ERR);

endmodule

// File: tb/tb_ars_ladder_ctrl.sv
// tb_ars_ladder_ctrl
// Drives ars_ladder_ctrl with point-unit stubs of fixed latency (add 5,
// double 3) returning tagged functions of their operands, and compares the
// final ladder pair, latency and launch timing against a ladder model.
`timescale 1ns/1ps
module tb_ars_ladder_ctrl;
    import ars_ecc_pkg::*;

    localparam int LA        = 5;
    localparam int LD        = 3;
    localparam int LMAX      = (LA > LD) ? LA : LD;
    localparam int STEP_CYC  = LMAX + 3;
    localparam int RUN_LIMIT = 4000;

    localparam logic [M-1:0] TAG_D1 = M'(32'hD0B1_E001);
    localparam logic [M-1:0] TAG_D2 = M'(32'h0DB1_5EED);
    localparam logic [M-1:0] TAG_A1 = M'(32'hADD0_A001);
    localparam logic [M-1:0] TAG_A2 = M'(32'h5A5A_C3C3);

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fails  = 0;
    int   cyc      = 0;

    ars_ladder_ctrl_if bus ();

    ars_ladder_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [M-1:0] rotl(input logic [M-1:0] v, input int s);
        return (v << s) | (v >> (M - s));
    endfunction

    function automatic logic [M-1:0] dbl_x(input logic [M-1:0] x, input logic [M-1:0] z);
        return rotl(x, 1) ^ rotl(z, 7) ^ TAG_D1;
    endfunction

    function automatic logic [M-1:0] dbl_z(input logic [M-1:0] x, input logic [M-1:0] z);
        return x + rotl(z, 3) + TAG_D2;
    endfunction

    function automatic logic [M-1:0] add_x(input logic [M-1:0] x1, input logic [M-1:0] z1,
                                           input logic [M-1:0] x2, input logic [M-1:0] z2,
                                           input logic [M-1:0] b);
        return ((x1 + rotl(x2, 2)) ^ z2 ^ b ^ TAG_A1) + z1;
    endfunction

    function automatic logic [M-1:0] add_z(input logic [M-1:0] x1, input logic [M-1:0] z1,
                                           input logic [M-1:0] x2, input logic [M-1:0] z2);
        return rotl(z1, 5) + z2 + (x1 ^ rotl(x2, 11)) + TAG_A2;
    endfunction

    function automatic logic [M-1:0] rnd_elem();
        logic [255:0] t;
        for (int w = 0; w < 8; w++) t[w*32 +: 32] = $urandom();
        return t[M-1:0];
    endfunction

    // Point-unit stubs: rdy is high during the L-th cycle of enable.
    int pa_cnt = 0;
    int pd_cnt = 0;
    always @(posedge clk) begin
        pa_cnt <= bus.pa_en ? pa_cnt + 1 : 0;
        pd_cnt <= bus.pd_en ? pd_cnt + 1 : 0;
    end
    assign bus.pa_rdy = bus.pa_en && (pa_cnt == LA - 1);
    assign bus.pd_rdy = bus.pd_en && (pd_cnt == LD - 1);
    assign bus.pa_X3  = add_x(bus.X1, bus.Z1, bus.X2, bus.Z2, bus.pa_x0);
    assign bus.pa_Z3  = add_z(bus.X1, bus.Z1, bus.X2, bus.Z2);
    assign bus.pd_X3  = dbl_x(bus.pd_X, bus.pd_Z);
    assign bus.pd_Z3  = dbl_z(bus.pd_X, bus.pd_Z);

    task automatic checkOutput(input string tag, input logic [M-1:0] obs, input logic [M-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Enable edge log and operand-stability snapshots, sampled on the falling edge.
    logic pa_prev = 1'b0;
    logic pd_prev = 1'b0;
    int   pa_rise[$];
    int   pa_fall[$];
    int   pd_rise[$];
    int   pd_fall[$];
    logic [M-1:0] pa_op_x1, pa_op_z1, pa_op_x2, pa_op_z2, pd_op_x, pd_op_z;

    always @(negedge clk) begin
        if (bus.pa_en && !pa_prev) begin
            pa_rise.push_back(cyc);
            pa_op_x1 <= bus.X1;
            pa_op_z1 <= bus.Z1;
            pa_op_x2 <= bus.X2;
            pa_op_z2 <= bus.Z2;
        end
        if (!bus.pa_en && pa_prev) pa_fall.push_back(cyc);
        if (bus.pd_en && !pd_prev) begin
            pd_rise.push_back(cyc);
            pd_op_x <= bus.pd_X;
            pd_op_z <= bus.pd_Z;
        end
        if (!bus.pd_en && pd_prev) pd_fall.push_back(cyc);
        if (bus.pa_en && pa_prev && bus.pa_rdy) begin
            checkOutput("pa_opnd_x1", bus.X1, pa_op_x1);
            checkOutput("pa_opnd_z1", bus.Z1, pa_op_z1);
            checkOutput("pa_opnd_x2", bus.X2, pa_op_x2);
            checkOutput("pa_opnd_z2", bus.Z2, pa_op_z2);
        end
        if (bus.pd_en && pd_prev && bus.pd_rdy) begin
            checkOutput("pd_opnd_x", bus.pd_X, pd_op_x);
            checkOutput("pd_opnd_z", bus.pd_Z, pd_op_z);
        end
        pa_prev <= bus.pa_en;
        pd_prev <= bus.pd_en;
    end

    // One complete run: model, launch, wait, compare, release.
    task automatic applyStimulus(input logic [KW-1:0] kv, input logic [M-1:0] xv, output int lat);
        int p;
        int lz;
        int n_steps;
        int dbl0_idx;
        int exp_lat;
        bit seen;
        logic [M-1:0] r1x, r1z, r2x, r2z, ax, az, dx, dz;

        p = -1;
        for (int j = KW - 1; j >= 0; j--) if (kv[j] && p < 0) p = j;
        lz = KW - 1 - p;
`ifdef ARS_LADDER_CT_EN
        n_steps  = KW - 1;
        dbl0_idx = lz;
        exp_lat  = 1 + 1 + lz * STEP_CYC + 1 + (LD + 1) + p * STEP_CYC;
`else
        n_steps  = p;
        dbl0_idx = 0;
        exp_lat  = 1 + (lz + 1) + 1 + (LD + 1) + p * STEP_CYC;
`endif
        r1x = xv;
        r1z = ONE;
        r2x = dbl_x(r1x, r1z);
        r2z = dbl_z(r1x, r1z);
        for (int j = p - 1; j >= 0; j--) begin
            ax = add_x(r1x, r1z, r2x, r2z, xv);
            az = add_z(r1x, r1z, r2x, r2z);
            if (kv[j]) begin
                dx = dbl_x(r2x, r2z);
                dz = dbl_z(r2x, r2z);
                r1x = ax; r1z = az; r2x = dx; r2z = dz;
            end else begin
                dx = dbl_x(r1x, r1z);
                dz = dbl_z(r1x, r1z);
                r2x = ax; r2z = az; r1x = dx; r1z = dz;
            end
        end

        pa_rise.delete(); pa_fall.delete(); pd_rise.delete(); pd_fall.delete();
        @(negedge clk);
        bus.k  = kv;
        bus.x0 = xv;
        bus.en = 1'b1;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < RUN_LIMIT) begin
            @(negedge clk);
            lat++;
            seen = bus.rdy || bus.err;
        end
        checkOutput("run_finished", M'(seen), M'(1'b1));

        if (p < 0) begin
            checkOutput("err_set", M'(bus.err), M'(1'b1));
            checkOutput("err_within_3", M'(lat <= 3), M'(1'b1));
            repeat (3) @(negedge clk);
            checkOutput("err_held", M'(bus.err), M'(1'b1));
            checkOutput("err_no_rdy", M'(bus.rdy), '0);
            checkOutput("err_no_launch", M'(pa_rise.size() + pd_rise.size()), '0);
            checkOutput("err_x1", bus.X1, '0);
        end else if (seen) begin
            checkOutput("rdy_set", M'(bus.rdy), M'(1'b1));
            checkOutput("latency", M'(lat), M'(exp_lat));
            checkOutput("X1", bus.X1, r1x);
            checkOutput("Z1", bus.Z1, r1z);
            checkOutput("X2", bus.X2, r2x);
            checkOutput("Z2", bus.Z2, r2z);
            checkOutput("pa_launches", M'(pa_rise.size()), M'(n_steps));
            checkOutput("pd_launches", M'(pd_rise.size()), M'(n_steps + 1));
            if (p >= 1 && pa_rise.size() == n_steps && pa_fall.size() == n_steps &&
                pd_rise.size() == n_steps + 1 && pd_fall.size() == n_steps + 1) begin
                checkOutput("step_rise_align",
                            M'(pa_rise[n_steps-1]), M'(pd_rise[n_steps]));
                checkOutput("step_fall_skew",
                            M'(pa_fall[n_steps-1] - pd_fall[n_steps]), M'(LA - LD));
                // Enable low for the capture cycle plus the single GAP cycle.
                checkOutput("dbl0_gap",
                            M'(pd_rise[dbl0_idx+1] - pd_fall[dbl0_idx]), M'(2));
            end
            repeat (3) @(negedge clk);
            checkOutput("rdy_held", M'(bus.rdy), M'(1'b1));
        end

        bus.en = 1'b0;
        @(negedge clk);
        checkOutput("rdy_cleared", M'(bus.rdy), '0);
        checkOutput("err_cleared", M'(bus.err), '0);
        checkOutput("x2_cleared", bus.X2, '0);
        checkOutput("pa_x0_cleared", bus.pa_x0, '0);
    endtask

    initial begin
        int lat;
        int lat_k1;
        int lat_msb;
        int n;
        logic [KW-1:0] kv;

        rst    = 1'b1;
        bus.en = 1'b0;
        bus.k  = '0;
        bus.x0 = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset_rdy", M'(bus.rdy), '0);
        checkOutput("reset_err", M'(bus.err), '0);
        checkOutput("reset_pa_en", M'(bus.pa_en), '0);
        checkOutput("reset_pd_en", M'(bus.pd_en), '0);
        checkOutput("reset_X1", bus.X1, '0);
        checkOutput("reset_Z1", bus.Z1, '0);
        checkOutput("reset_pd_X", bus.pd_X, '0);
        checkOutput("reset_pa_x0", bus.pa_x0, '0);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] k = 0");
        applyStimulus('0, rnd_elem(), lat);
        $display("[TB] k = 1, 3, 2");
        applyStimulus(KW'(1), rnd_elem(), lat_k1);
        applyStimulus(KW'(3), rnd_elem(), lat);
        applyStimulus(KW'(2), rnd_elem(), lat);
        $display("[TB] k = MSB only");
        kv = '0;
        kv[KW-1] = 1'b1;
        applyStimulus(kv, rnd_elem(), lat_msb);
`ifdef ARS_LADDER_CT_EN
        checkOutput("latency_diff", M'(lat_k1 - lat_msb), '0);
`else
        checkOutput("latency_diff", M'(lat_k1 - lat_msb), M'((KW - 1) - (KW - 1) * STEP_CYC));
`endif

        $display("[TB] random scalars");
        for (int r = 0; r < 4; r++) begin
            kv = rnd_elem();
            if (r < 2) kv = kv & KW'(32'hFFFF);
            applyStimulus(kv, rnd_elem(), lat);
        end

        $display("[TB] en dropped during STEP");
        @(negedge clk);
        bus.k  = rnd_elem() | {1'b1, {(KW-1){1'b0}}};
        bus.x0 = rnd_elem();
        bus.en = 1'b1;
        n = 0;
        while (!bus.pa_en && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("reached_step", M'(bus.pa_en), M'(1'b1));
        bus.en = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("abort_pa_en", M'(bus.pa_en), '0);
        checkOutput("abort_pd_en", M'(bus.pd_en), '0);
        checkOutput("abort_X1", bus.X1, '0);
        checkOutput("abort_Z2", bus.Z2, '0);
        applyStimulus(rnd_elem() & KW'(32'hFFF), rnd_elem(), lat);

        $display("[TB] rst asserted during DBL0");
        @(negedge clk);
        bus.k  = rnd_elem() | {1'b1, {(KW-1){1'b0}}};
        bus.x0 = rnd_elem();
        bus.en = 1'b1;
        n = 0;
        while (!bus.pd_en && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("reached_dbl0", M'(bus.pd_en), M'(1'b1));
        #1 rst = 1'b1;
        #1;
        checkOutput("rst_pd_en", M'(bus.pd_en), '0);
        checkOutput("rst_X1", bus.X1, '0);
        checkOutput("rst_Z1", bus.Z1, '0);
        checkOutput("rst_pa_x0", bus.pa_x0, '0);
        @(negedge clk);
        bus.en = 1'b0;
        rst    = 1'b0;
        @(negedge clk);
        applyStimulus(KW'(3), rnd_elem(), lat);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
